// File: rtl/mio_bus_ctrl_if.sv
// CPU-side and RAM-side bus signals of the memory/IO controller.
// The slave modport is the controller's view; the master modport is the CPU/RAM model's view.
interface mio_bus_ctrl_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        ram_en;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output cpu_rdata, cpu_ready, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  cpu_rdata, cpu_ready, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mio_bus_ctrl.sv
// CPU memory/IO bus controller: decodes RAM, GPIO, switch and timer accesses.
// Optional free-running timer is enabled by defining MIO_TIMER_EN.
module mio_bus_ctrl #(
    parameter int RAM_WAIT = 1
) (
    input  logic               clk,
    input  logic               reset,
    mio_bus_ctrl_if.slave      bus,
    input  logic [15:0]        sw_in,
    output logic [15:0]        gpio_out,
    output logic               bus_err,
    output logic [2:0]         state
);

    // Handshake: a request is accepted on the first rising edge in IDLE with
    // cpu_req=1; completion is a single-cycle cpu_ready pulse, after which the
    // controller waits in REL for cpu_req=0 before accepting anything new.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RAM  = 3'd1,
        S_WAIT = 3'd2,
        S_IO   = 3'd3,
        S_DONE = 3'd4,
        S_REL  = 3'd5
    } state_t;

    localparam logic [31:0] GPIO_ADDR  = 32'hE000_0000;
    localparam logic [31:0] SW_ADDR    = 32'hF000_0000;
    localparam logic [31:0] TIMER_ADDR = 32'hF000_0004;
    localparam logic [2:0]  WAIT_LOAD  = 3'(RAM_WAIT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_wait_cnt;
    logic [31:0] r_cpu_rdata;
    logic [15:0] r_gpio;
    logic        r_bus_err;
    logic [31:0] w_timer;

    logic        w_ram_en;
    logic        w_ram_we;
    logic        w_ready;

    // Decode of the incoming address, used only at the accepting edge.
    logic        w_in_aligned;
    logic        w_in_ram;
    logic        w_in_io;
    logic        w_in_ok;

    // Decode of the latched address, used during the IO cycle.
    logic        w_hit_gpio;
    logic        w_hit_sw;
    logic        w_hit_timer;
    logic [31:0] w_io_rdata;

`ifdef MIO_TIMER_EN
    logic [31:0] r_timer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    assign w_timer = r_timer;
`else
    assign w_timer = '0;
`endif

    always_comb begin
        w_in_aligned = (bus.cpu_addr[1:0] == 2'b00);
        w_in_ram     = (bus.cpu_addr[31:14] == '0);
        w_in_io      = (bus.cpu_addr == GPIO_ADDR) ||
                       (bus.cpu_addr == SW_ADDR)   ||
                       (bus.cpu_addr == TIMER_ADDR);
        w_in_ok      = w_in_aligned && (w_in_ram || w_in_io);
    end

    always_comb begin
        w_hit_gpio  = (r_addr == GPIO_ADDR);
        w_hit_sw    = (r_addr == SW_ADDR);
        w_hit_timer = (r_addr == TIMER_ADDR);
        w_io_rdata  = '0;
        if (w_hit_gpio) begin
            w_io_rdata = {16'h0000, r_gpio};
        end else if (w_hit_sw) begin
            w_io_rdata = {16'h0000, sw_in};
        end else if (w_hit_timer) begin
            w_io_rdata = w_timer;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_ram_en = 1'b0;
        w_ram_we = 1'b0;
        w_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cpu_req) begin
                    if (!w_in_ok) begin
                        w_next = S_DONE;
                    end else if (w_in_ram) begin
                        w_next = S_RAM;
                    end else begin
                        w_next = S_IO;
                    end
                end
            end
            S_RAM: begin
                w_ram_en = 1'b1;
                w_ram_we = r_we;
                w_next   = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_cnt == 3'd0) begin
                    w_next = S_DONE;
                end
            end
            S_IO: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                w_ready = 1'b1;
                w_next  = S_REL;
            end
            S_REL: begin
                if (!bus.cpu_req) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wait_cnt  <= '0;
            r_cpu_rdata <= '0;
            r_gpio      <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cpu_req) begin
                        r_we    <= bus.cpu_we;
                        r_addr  <= bus.cpu_addr;
                        r_wdata <= bus.cpu_wdata;
                        // Errors complete without an access; read data is forced to zero.
                        if (!w_in_ok) begin
                            r_bus_err   <= 1'b1;
                            r_cpu_rdata <= '0;
                        end
                    end
                end
                S_RAM: begin
                    r_wait_cnt <= WAIT_LOAD;
                end
                S_WAIT: begin
                    if (r_wait_cnt != 3'd0) begin
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                    end else if (!r_we) begin
                        r_cpu_rdata <= bus.ram_rdata;
                    end
                end
                S_IO: begin
                    // Writes to the read-only switch and timer locations are dropped silently.
                    if (r_we) begin
                        if (w_hit_gpio) begin
                            r_gpio <= r_wdata[15:0];
                        end
                    end else begin
                        r_cpu_rdata <= w_io_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.cpu_ready = w_ready;
    assign bus.ram_en    = w_ram_en;
    assign bus.ram_we    = w_ram_we;
    assign bus.ram_addr  = r_addr[13:2];
    assign bus.ram_wdata = r_wdata;
    assign gpio_out      = r_gpio;
    assign bus_err       = r_bus_err;
    assign state         = r_state;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed bench for mio_bus_ctrl with RAM_WAIT=3: a vector table of single
// transactions plus hand-written timer, early-release and reset-abort sequences.
module tb_mio_bus_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] sw_in;
    logic [15:0] gpio_out;
    logic        bus_err;
    logic [2:0]  state;
    int          cyc;
    int          n_vec;
    int          n_err;

    mio_bus_ctrl_if bus ();

    mio_bus_ctrl #(.RAM_WAIT(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .sw_in    (sw_in),
        .gpio_out (gpio_out),
        .bus_err  (bus_err),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] sw;
        logic [31:0] rrd;
        int          hold;
        int          exp_lat;
        int          exp_en;
        logic [11:0] exp_ra;
        logic [31:0] exp_rdata;
        logic [15:0] exp_gpio;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic run_txn(
        input  logic        we,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [15:0] sw,
        input  logic [31:0] rrd,
        input  int          hold,
        input  bit          drop_early,
        output int          lat,
        output int          n_rdy,
        output int          n_en,
        output logic [11:0] ra,
        output bit          rel_ok,
        output logic [2:0]  end_state,
        output int          acc
    );
        bit seen;
        int waited;
        @(negedge clk);
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.ram_rdata = rrd;
        sw_in         = sw;
        bus.cpu_req   = 1'b1;
        @(posedge clk);
        #1 acc = cyc;
        lat = 0; n_rdy = 0; n_en = 0; ra = '0; rel_ok = 1'b1; seen = 1'b0;
        for (int k = 1; k <= 32 && !seen; k++) begin
            @(negedge clk);
            if (drop_early) bus.cpu_req = 1'b0;
            if (bus.ram_en) begin
                n_en++;
                ra = bus.ram_addr;
            end
            if (bus.cpu_ready) begin
                n_rdy++;
                lat  = k;
                seen = 1'b1;
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (bus.cpu_ready) n_rdy++;
            if (bus.ram_en) n_en++;
            if (state != 3'd5) rel_ok = 1'b0;
        end
        bus.cpu_req = 1'b0;
        waited = 0;
        do begin
            @(negedge clk);
            if (bus.cpu_ready) n_rdy++;
            if (bus.ram_en) n_en++;
            waited++;
        end while (state != 3'd0 && waited < 4);
        end_state = state;
    endtask

    initial begin
        int          lat, n_rdy, n_en, acc, acc1, acc2, guard;
        logic [11:0] ra;
        bit          rel_ok;
        logic [2:0]  end_state;
        logic [31:0] t1, t2;

        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        sw_in = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.ram_rdata = '0;

        //           we    addr          wdata         sw       rrd        hold lat en  ra      rdata         gpio     err
        vecs[0]  = '{1'b1, 32'hE000_0000, 32'h0001_A5A5, 16'h0000, 32'h0,       0, 2, 0, 12'h000, 32'h0000_0000, 16'hA5A5, 1'b0};
        vecs[1]  = '{1'b0, 32'hE000_0000, 32'h0,         16'h0000, 32'h0,       0, 2, 0, 12'h000, 32'h0000_A5A5, 16'hA5A5, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_3FFC, 32'h1234_5678, 16'h0000, 32'h0,       0, 5, 1, 12'hFFF, 32'h0000_A5A5, 16'hA5A5, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         16'h0000, 32'hDEADBEEF, 0, 5, 1, 12'h004, 32'hDEAD_BEEF, 16'hA5A5, 1'b0};
        vecs[4]  = '{1'b0, 32'hF000_0000, 32'h0,         16'h1234, 32'h0,      10, 2, 0, 12'h000, 32'h0000_1234, 16'hA5A5, 1'b0};
        vecs[5]  = '{1'b1, 32'hF000_0000, 32'hFFFF_FFFF, 16'h1234, 32'h0,       0, 2, 0, 12'h000, 32'h0000_1234, 16'hA5A5, 1'b0};
        vecs[6]  = '{1'b1, 32'hF000_0004, 32'hFFFF_FFFF, 16'h1234, 32'h0,       0, 2, 0, 12'h000, 32'h0000_1234, 16'hA5A5, 1'b0};
        vecs[7]  = '{1'b0, 32'h8000_0000, 32'h0,         16'h0000, 32'h1111,    0, 1, 0, 12'h000, 32'h0000_0000, 16'hA5A5, 1'b1};
        vecs[8]  = '{1'b0, 32'h0000_0002, 32'h0,         16'h0000, 32'h2222,    0, 1, 0, 12'h000, 32'h0000_0000, 16'hA5A5, 1'b1};
        vecs[9]  = '{1'b0, 32'h0000_4000, 32'h0,         16'h0000, 32'h3333,    0, 1, 0, 12'h000, 32'h0000_0000, 16'hA5A5, 1'b1};
        vecs[10] = '{1'b1, 32'hE000_0004, 32'h0000_BBBB, 16'h0000, 32'h0,       0, 1, 0, 12'h000, 32'h0000_0000, 16'hA5A5, 1'b1};
        vecs[11] = '{1'b1, 32'hE000_0000, 32'h0000_5A5A, 16'h0000, 32'h0,       3, 2, 0, 12'h000, 32'h0000_0000, 16'h5A5A, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_gpio", {16'd0, gpio_out}, 32'd0);
        check("rst_rdata", bus.cpu_rdata, 32'd0);
        check("rst_err", {31'd0, bus_err}, 32'd0);
        check("rst_ready", {31'd0, bus.cpu_ready}, 32'd0);
        check("rst_ram_en", {31'd0, bus.ram_en}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sw, vecs[i].rrd,
                    vecs[i].hold, 1'b0, lat, n_rdy, n_en, ra, rel_ok, end_state, acc);
            $display("vector %0d addr %h we %0d", i, vecs[i].addr, vecs[i].we);
            check("latency", lat, vecs[i].exp_lat);
            check("ready_pulses", n_rdy, 1);
            check("ram_en_pulses", n_en, vecs[i].exp_en);
            if (vecs[i].exp_en > 0) check("ram_addr", {20'd0, ra}, {20'd0, vecs[i].exp_ra});
            check("rdata", bus.cpu_rdata, vecs[i].exp_rdata);
            check("gpio", {16'd0, gpio_out}, {16'd0, vecs[i].exp_gpio});
            check("bus_err", {31'd0, bus_err}, {31'd0, vecs[i].exp_err});
            if (vecs[i].hold > 0) check("held_in_rel", {31'd0, rel_ok}, 32'd1);
            check("end_idle", {29'd0, end_state}, 32'd0);
        end

        // Two timer reads exactly 20 cycles apart
        run_txn(1'b0, 32'hF000_0004, 32'h0, 16'h0, 32'h0, 0, 1'b0, lat, n_rdy, n_en, ra, rel_ok, end_state, acc1);
        t1 = bus.cpu_rdata;
        check("timer1_latency", lat, 2);
        guard = 0;
        while (cyc < acc1 + 18 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        run_txn(1'b0, 32'hF000_0004, 32'h0, 16'h0, 32'h0, 0, 1'b0, lat, n_rdy, n_en, ra, rel_ok, end_state, acc2);
        t2 = bus.cpu_rdata;
        check("timer_gap", acc2 - acc1, 32'd20);
`ifdef MIO_TIMER_EN
        check("timer_diff", t2 - t1, 32'd20);
`else
        check("timer1_zero", t1, 32'd0);
        check("timer2_zero", t2, 32'd0);
`endif
        check("timer_no_err_change", {31'd0, bus_err}, 32'd1);

        // Reset during the IO cycle of a GPIO write
        @(negedge clk);
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'hE000_0000;
        bus.cpu_wdata = 32'h0000_FFFF;
        bus.cpu_req   = 1'b1;
        @(negedge clk);
        check("abort_in_io", {29'd0, state}, 32'd3);
        reset = 1'b0;
        #1;
        check("abort_state", {29'd0, state}, 32'd0);
        check("abort_gpio", {16'd0, gpio_out}, 32'd0);
        check("abort_err", {31'd0, bus_err}, 32'd0);
        check("abort_rdata", bus.cpu_rdata, 32'd0);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        reset = 1'b1;
        n_rdy = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.cpu_ready) n_rdy++;
        end
        check("abort_no_ready", n_rdy, 0);
        check("abort_gpio_after", {16'd0, gpio_out}, 32'd0);
        check("abort_idle", {29'd0, state}, 32'd0);

        // Request dropped right after acceptance still completes
        run_txn(1'b0, 32'h0000_0020, 32'h0, 16'h0, 32'hCAFE_F00D, 0, 1'b1, lat, n_rdy, n_en, ra, rel_ok, end_state, acc);
        check("early_latency", lat, 5);
        check("early_ready", n_rdy, 1);
        check("early_ram_addr", {20'd0, ra}, 32'd8);
        check("early_rdata", bus.cpu_rdata, 32'hCAFE_F00D);
        check("early_idle", {29'd0, end_state}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
